// File: rtl/p405s_timer_pit_if.sv
// SPR access bus between the core pipeline and the PIT block.
// The master drives the move-to/from strobes and write data; the slave returns read data.
interface p405s_timer_pit_if;
  logic        PCL_mtSPR;
  logic        PCL_mfSPR;
  logic        PCL_sprHold;
  logic        pitDcd;
  logic        tcrDcd;
  logic        tsrDcd;
  logic [0:31] EXE_sprDataBus;
  logic [0:31] sprDataOut;

  modport master (
    output PCL_mtSPR, PCL_mfSPR, PCL_sprHold, pitDcd, tcrDcd, tsrDcd, EXE_sprDataBus,
    input  sprDataOut
  );

  modport slave (
    input  PCL_mtSPR, PCL_mfSPR, PCL_sprHold, pitDcd, tcrDcd, tsrDcd, EXE_sprDataBus,
    output sprDataOut
  );
endinterface

// File: rtl/p405s_timer_pit.sv
// Programmable interval timer: decrements on time-base ticks, flags PIS on expiry,
// optionally auto-reloads, and exposes PIT/TCR/TSR through the SPR bus.
module p405s_timer_pit (
  input  logic                       CB,
  input  logic                       sysResetNEG,
  input  logic                       timerTic,
  input  logic                       freezeTimersNEG,
  p405s_timer_pit_if.slave           spr_bus,
  output logic [0:31]                pitL2,
  output logic                       pitStatus,
  output logic                       pitIntReq
);

  logic [0:31] pit_q, pit_d;
  logic [0:31] reload_q, reload_d;
  logic        pie_q, pie_d;
  logic        are_q, are_d;
  logic        pis_q, pis_d;
  logic [0:31] rd_q, rd_d;

  logic spr_ok;
  logic pit_wr, tcr_wr, tsr_wr;
  logic pit_rd, tcr_rd, tsr_rd;
  logic dec_en, expire;

  always_comb begin
    spr_ok = ~spr_bus.PCL_sprHold;
    pit_wr = spr_bus.PCL_mtSPR & spr_bus.pitDcd & spr_ok;
    tcr_wr = spr_bus.PCL_mtSPR & spr_bus.tcrDcd & spr_ok;
    tsr_wr = spr_bus.PCL_mtSPR & spr_bus.tsrDcd & spr_ok;
    pit_rd = spr_bus.PCL_mfSPR & spr_bus.pitDcd & spr_ok;
    tcr_rd = spr_bus.PCL_mfSPR & spr_bus.tcrDcd & spr_ok;
    tsr_rd = spr_bus.PCL_mfSPR & spr_bus.tsrDcd & spr_ok;
    // A PIT write swallows a coincident tick entirely.
    dec_en = timerTic & freezeTimersNEG & (pit_q != 32'd0) & ~pit_wr;
    expire = dec_en & (pit_q == 32'd1);
  end

  always_comb begin
    pit_d    = pit_q;
    reload_d = reload_q;
    pie_d    = pie_q;
    are_d    = are_q;
    pis_d    = pis_q;
    rd_d     = '0;

    if (pit_wr) begin
      pit_d    = spr_bus.EXE_sprDataBus;
      reload_d = spr_bus.EXE_sprDataBus;
    end else if (expire) begin
      pit_d = are_q ? reload_q : 32'd0;
    end else if (dec_en) begin
      pit_d = pit_q - 32'd1;
    end

    if (tcr_wr) begin
      pie_d = spr_bus.EXE_sprDataBus[4];
      are_d = spr_bus.EXE_sprDataBus[9];
    end

    // Expiry set has priority over a write-one-to-clear in the same cycle.
    if (expire) begin
      pis_d = 1'b1;
    end else if (tsr_wr && spr_bus.EXE_sprDataBus[4]) begin
      pis_d = 1'b0;
    end

    if (pit_rd) begin
      rd_d = rd_d | pit_q;
    end
    if (tcr_rd) begin
      rd_d[4] = rd_d[4] | pie_q;
      rd_d[9] = rd_d[9] | are_q;
    end
    if (tsr_rd) begin
      rd_d[4] = rd_d[4] | pis_q;
    end
  end

  always_ff @(posedge CB) begin
    if (!sysResetNEG) begin
      pit_q    <= '0;
      reload_q <= '0;
      pie_q    <= 1'b0;
      are_q    <= 1'b0;
      pis_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      pit_q    <= pit_d;
      reload_q <= reload_d;
      pie_q    <= pie_d;
      are_q    <= are_d;
      pis_q    <= pis_d;
      rd_q     <= rd_d;
    end
  end

  assign pitL2              = pit_q;
  assign pitStatus          = pis_q;
  assign pitIntReq          = pis_q & pie_q;
  assign spr_bus.sprDataOut = rd_q;

endmodule

// File: doc/p405s_timer_pit.md
P405S_TIMER_PIT -- requirements
Module: p405s_timer_pit

Interface
REQ-001 SHALL use a single clock and a synchronous, active-low reset: one clock (CB); reset is synchronous and active-low (sysResetNEG).
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- CB  in  1  core clock; all state updates on its rising edge.
- sysResetNEG  in  1  synchronous active-low reset.
- timerTic  in  1  one-cycle time-base tick pulse from the time-base block.
- freezeTimersNEG  in  1  low = timers frozen (debug/JTAG).
- PCL_mtSPR  in  1  move-to-SPR strobe.
- PCL_mfSPR  in  1  move-from-SPR strobe.
- PCL_sprHold  in  1  SPR access stalled; blocks all SPR accesses.
- pitDcd  in  1  SPR number decodes to PIT.
- tcrDcd  in  1  SPR number decodes to TCR.
- tsrDcd  in  1  SPR number decodes to TSR.
- EXE_sprDataBus  in  32 [0:31]  SPR write data.
- pitL2  out  32 [0:31]  current PIT count.
- pitStatus  out  1  TSR[PIS], the PIT event status.
- pitIntReq  out  1  PIT interrupt request.
- sprDataOut  out  32 [0:31]  registered mfSPR read data.

Function
REQ-003 SHALL define a qualified write as PCL_mtSPR & xDcd & ~PCL_sprHold, and a qualified read as PCL_mfSPR & xDcd & ~PCL_sprHold.
REQ-004 SHALL define a decrement enable as timerTic & freezeTimersNEG & (pitL2 != 0) & ~(qualified PIT write).
REQ-005 SHALL, on a qualified PIT write, load both pitL2 and an internal 32-bit reload register from EXE_sprDataBus[0:31] at the next edge.
REQ-006 SHALL, when the decrement enable is true and pitL2 > 1, set pitL2 to pitL2 - 1 (unsigned, 32-bit) with no other effect.
REQ-007 SHALL, when the decrement enable is true and pitL2 == 1 (the expiry event), set PIS; pitL2 then loads the reload register if ARE = 1, else becomes 0.
REQ-008 SHALL, when pitL2 == 0, hold pitL2 and generate no expiry event regardless of timerTic.
REQ-009 SHALL, on a PIT write coinciding with timerTic, let the write win: no decrement and no PIS set from that tick.
REQ-010 SHALL, on a qualified TCR write, capture PIE from EXE_sprDataBus[4] and ARE from EXE_sprDataBus[9]; all other TCR bits are not owned by this block.
REQ-011 SHALL, on a qualified TSR write, clear PIS when EXE_sprDataBus[4] = 1 (write-one-to-clear); writing 0 has no effect.
REQ-012 SHALL, when an expiry event and a TSR clear occur in the same cycle, leave PIS set (set wins).
REQ-013 SHALL drive pitStatus = PIS and pitIntReq = PIS & PIE, both purely from registered state with no input-to-output combinational path.
REQ-014 SHALL, one cycle after a qualified read, drive sprDataOut with the following values, and otherwise drive it as 0x00000000:
- PIT read: pitL2 as sampled in the read cycle.
- TCR read: bit 4 = PIE, bit 9 = ARE, all other bits 0.
- TSR read: bit 4 = PIS, all other bits 0.
REQ-015 SHALL, with freezeTimersNEG low, hold pitL2 and PIS against timer ticks, while SPR writes and reads still take effect.
REQ-016 SHALL, when ARE = 1 and the reload register = 0, set PIS at expiry, load pitL2 with 0, and stop counting.
REQ-017 SHALL give PCL_sprHold priority over any strobe: with PCL_sprHold high, no register changes due to an SPR access.

Reset
REQ-018 SHALL, when sysResetNEG is low at a rising edge of CB, clear pitL2, the reload register, PIE, ARE, PIS and sprDataOut to 0, overriding every simultaneous write or tick.
REQ-019 SHALL hold pitL2 = 0x00000000, pitStatus = 0, pitIntReq = 0 and sprDataOut = 0x00000000 on the first cycle after reset releases.

Verification
REQ-020 SHALL be verified with the following directed scenarios:
- One-shot expiry: write PIT=3, ARE=0, PIE=1; 3 ticks -> pitL2 2,1,0; pitStatus=1 and pitIntReq=1 after the third tick; further ticks leave pitL2=0.
- Auto-reload: ARE=1, PIT=2; 4 ticks -> pitL2 1,2,1,2; PIS set after the 2nd tick; a TSR write of 0x08000000 clears it.
- Collision: PIT write 0x10 in the same cycle as a tick with pitL2=1 -> pitL2=0x10 and PIS stays 0; a TSR clear concurrent with expiry -> PIS=1.
- Freeze and hold: freezeTimersNEG=0 for 5 ticks -> pitL2 unchanged; a PIT write with PCL_sprHold=1 -> no change.
- Readback: mfSPR of PIT, TCR and TSR -> the correct values in sprDataOut one cycle later; 0 in idle cycles.
- Reset mid-count: pitL2=0x55 with PIS=1 and a reset asserted concurrently with a tick and a write -> all outputs read 0 on the next cycle.
